fmap_streamer: RTL and testbench

FMAP_STREAMER -- requirements
Module: fmap_streamer

---
 rtl/nn_pkg.sv | 20 ++
 rtl/fmap_mem_if.sv | 22 ++
 rtl/fmap_addr_gen.sv | 71 +++++++
 rtl/fmap_streamer.sv | 127 ++++++++++++
 tb/tb_fmap_streamer.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nn_pkg.sv
// Shared definitions for the feature-map streamers:
// FSM encoding plus padded-side and counter-width helpers.
package nn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_GAP,
        ST_DRAIN
    } stream_state_e;

    function automatic int side_len(input int in_sz, input int pad);
        return in_sz + 2 * pad;
    endfunction

    function automatic int cnt_width(input int p);
        return (p > 1) ? $clog2(p) : 1;
    endfunction

endpackage

// File: rtl/fmap_mem_if.sv
// Synchronous-read memory port used by the streamers.
// The streamer is master; the memory is slave.
interface fmap_mem_if #(
    parameter int N      = 8,
    parameter int ADDR_W = 16
);
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [N-1:0]      mem_rdata;

    modport master (
        output mem_rd_en,
        output mem_addr,
        input  mem_rdata
    );

    modport slave (
        input  mem_rd_en,
        input  mem_addr,
        output mem_rdata
    );
endinterface

// File: rtl/fmap_addr_gen.sv
// Raster row/col walker over the padded map: pad flag,
// last-pixel flag and wrapped read address for the current pixel.
module fmap_addr_gen
    import nn_pkg::*;
#(
    parameter int INPUT_SIZE = 6,
    parameter int PADDING    = 0,
    parameter int ADDR_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              pad,
    output logic              last,
    output logic [ADDR_W-1:0] addr
);
    localparam int P  = side_len(INPUT_SIZE, PADDING);
    localparam int CW = cnt_width(P);

    logic [CW-1:0]     row_q, row_d;
    logic [CW-1:0]     col_q, col_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] r_off, c_off;

    assign last = (row_q == CW'(P - 1)) && (col_q == CW'(P - 1));

    assign pad = (int'(row_q) < PADDING)
              || (int'(row_q) >= PADDING + INPUT_SIZE)
              || (int'(col_q) < PADDING)
              || (int'(col_q) >= PADDING + INPUT_SIZE);

    // Offsets wrap naturally at ADDR_W bits
    assign r_off = ADDR_W'(row_q) - ADDR_W'(PADDING);
    assign c_off = ADDR_W'(col_q) - ADDR_W'(PADDING);
    assign addr  = base_q + r_off * ADDR_W'(INPUT_SIZE) + c_off;

    always_comb begin
        row_d  = row_q;
        col_d  = col_q;
        base_d = base_q;
        if (load) begin
            row_d  = '0;
            col_d  = '0;
            base_d = base_addr;
        end else if (step) begin
            if (last) begin
                row_d = '0;
                col_d = '0;
            end else if (col_q == CW'(P - 1)) begin
                col_d = '0;
                row_d = row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_q  <= '0;
            col_q  <= '0;
            base_q <= '0;
        end else begin
            row_q  <= row_d;
            col_q  <= col_d;
            base_q <= base_d;
        end
    end
endmodule

// File: rtl/fmap_streamer.sv
// Streams a zero-padded feature map from memory into conv_unit,
// one pixel per issue slot with optional idle gaps.
module fmap_streamer
    import nn_pkg::*;
#(
    parameter int N          = 8,
    parameter int INPUT_SIZE = 6,
    parameter int PADDING    = 0,
    parameter int VLD_GAP    = 1,
    parameter int ADDR_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    fmap_mem_if.master        mem,
    output logic              out_vld,
    output logic [N-1:0]      out_dout,
    output logic              out_last,
    output logic              busy,
    output logic              done
);
    localparam int GW = (VLD_GAP > 1) ? $clog2(VLD_GAP) : 1;

    stream_state_e   state_q, state_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic            vld_q, vld_d;
    logic            pad_q, pad_d;
    logic            last_q, last_d;
    logic            done_q, done_d;
    logic            load, issue;
    logic            ag_pad, ag_last;
    logic [ADDR_W-1:0] ag_addr;

    fmap_addr_gen #(
        .INPUT_SIZE (INPUT_SIZE),
        .PADDING    (PADDING),
        .ADDR_W     (ADDR_W)
    ) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .step      (issue),
        .base_addr (base_addr),
        .pad       (ag_pad),
        .last      (ag_last),
        .addr      (ag_addr)
    );

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        vld_d   = vld_q;
        pad_d   = pad_q;
        last_d  = last_q;
        done_d  = done_q;
        load    = 1'b0;
        issue   = 1'b0;
        if (ce) begin
            vld_d  = 1'b0;
            pad_d  = 1'b0;
            last_d = 1'b0;
            done_d = 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    // A start seen alongside done waits one cycle
                    if (start && !done_q) begin
                        load    = 1'b1;
                        state_d = ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    issue  = 1'b1;
                    vld_d  = 1'b1;
                    pad_d  = ag_pad;
                    last_d = ag_last;
                    if (ag_last) begin
                        state_d = ST_DRAIN;
                    end else if (VLD_GAP > 0) begin
                        state_d = ST_GAP;
                        gap_d   = '0;
                    end
                end
                ST_GAP: begin
                    if (gap_q == GW'(VLD_GAP - 1)) begin
                        state_d = ST_ISSUE;
                    end else begin
                        gap_d = gap_q + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            gap_q   <= '0;
            vld_q   <= 1'b0;
            pad_q   <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            vld_q   <= vld_d;
            pad_q   <= pad_d;
            last_q  <= last_d;
            done_q  <= done_d;
        end
    end

    assign mem.mem_rd_en = issue && !ag_pad && !rst;
    assign mem.mem_addr  = mem.mem_rd_en ? ag_addr : '0;

    assign out_vld  = vld_q && ce && !rst;
    assign out_dout = (out_vld && !pad_q) ? mem.mem_rdata : '0;
    assign out_last = out_vld && last_q;
    assign busy     = !rst && ((state_q != ST_IDLE) || done_q);
    assign done     = done_q && ce && !rst;
endmodule

// File: tb/tb_fmap_streamer.sv
// Randomised bench for fmap_streamer against a closed-form
// frame-timing model, plus literal pins for selected frames.
module tb_fmap_streamer;
    localparam int NW = 8;
    localparam int AW = 16;
    localparam int IS = 3;
    localparam int PD = 1;
    localparam int G  = 2;
    localparam int P  = IS + 2 * PD;
    localparam int NP = P * P;
    localparam int K_DONE = 2 + (NP - 1) * (G + 1) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ce = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic          out_vld, out_last, busy, done;
    logic [NW-1:0] out_dout;

    fmap_mem_if #(.N(NW), .ADDR_W(AW)) mif ();

    fmap_streamer #(
        .N(NW), .INPUT_SIZE(IS), .PADDING(PD),
        .VLD_GAP(G), .ADDR_W(AW)
    ) dut (
        .clk(clk), .rst(rst), .ce(ce), .start(start),
        .base_addr(base_addr), .mem(mif),
        .out_vld(out_vld), .out_dout(out_dout),
        .out_last(out_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [NW-1:0] mem [0:65535];
    always @(posedge clk)
        if (mif.mem_rd_en) mif.mem_rdata <= mem[mif.mem_addr];

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at cyc", nm, act, exp);
        end
    endtask

    function automatic bit is_pad(input int j);
        int r, c;
        r = j / P;
        c = j % P;
        return r < PD || r >= PD + IS || c < PD || c >= PD + IS;
    endfunction

    function automatic logic [AW-1:0] pix_addr(input logic [AW-1:0] b,
                                               input int j);
        int r, c;
        r = j / P - PD;
        c = j % P - PD;
        return AW'(int'(b) + r * IS + c);
    endfunction

    // Model state: frame active from the cycle after acceptance
    // through the done cycle; k counts ce-high cycles since start.
    bit            m_active = 0;
    int            m_k = 0;
    logic [AW-1:0] m_base = '0;

    int cyc = 0, pix_cnt = 0, done_cnt = 0, rise_cnt = 0;
    bit busy_prev = 0;
    bit rec_en = 0;
    int rec_busy = 0;
    int done_cyc[$];
    int rise_cyc[$];
    logic [NW-1:0] obs_pix[$];
    logic [AW-1:0] obs_addr[$];

    always @(negedge clk) begin
        logic e_rd, e_vld, e_last, e_busy, e_done;
        logic [AW-1:0] e_addr;
        logic [NW-1:0] e_dout;
        int j;
        e_rd = 0; e_vld = 0; e_last = 0; e_busy = 0; e_done = 0;
        e_addr = '0; e_dout = '0;
        cyc++;
        if (!rst && m_active) begin
            e_busy = 1;
            if (ce) begin
                m_k++;
                if ((m_k - 1) % (G + 1) == 0 && (m_k - 1) / (G + 1) < NP) begin
                    j = (m_k - 1) / (G + 1);
                    if (!is_pad(j)) begin
                        e_rd = 1;
                        e_addr = pix_addr(m_base, j);
                    end
                end
                if (m_k >= 2 && (m_k - 2) % (G + 1) == 0
                    && (m_k - 2) / (G + 1) < NP) begin
                    j = (m_k - 2) / (G + 1);
                    e_vld = 1;
                    e_dout = is_pad(j) ? '0 : mem[pix_addr(m_base, j)];
                    e_last = (j == NP - 1);
                end
                e_done = (m_k == K_DONE);
            end
        end
        chk("mem_rd_en", 32'(mif.mem_rd_en), 32'(e_rd));
        if (e_rd) chk("mem_addr", 32'(mif.mem_addr), 32'(e_addr));
        if (rst) chk("mem_addr_rst", 32'(mif.mem_addr), 32'd0);
        chk("out_vld", 32'(out_vld), 32'(e_vld));
        chk("out_dout", 32'(out_dout), 32'(e_dout));
        chk("out_last", 32'(out_last), 32'(e_last));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("done", 32'(done), 32'(e_done));

        if (out_vld) pix_cnt++;
        if (done) begin
            done_cnt++;
            done_cyc.push_back(cyc);
        end
        if (busy && !busy_prev) begin
            rise_cnt++;
            rise_cyc.push_back(cyc);
        end
        busy_prev = busy;
        if (rec_en) begin
            if (out_vld) obs_pix.push_back(out_dout);
            if (mif.mem_rd_en) obs_addr.push_back(mif.mem_addr);
            if (busy) rec_busy++;
        end

        if (rst) m_active = 0;
        else if (e_done) m_active = 0;
        else if (!m_active && ce && start) begin
            m_active = 1;
            m_k = 0;
            m_base = base_addr;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_done(input int target, input int budget);
        int i = 0;
        while (done_cnt < target && i < budget) begin
            tick(1);
            i++;
        end
        total++;
        if (done_cnt < target) begin
            bad++;
            $display("FAIL wait_done: got %0d want %0d", done_cnt, target);
        end
    endtask

    task automatic wait_pix(input int target, input int budget);
        int i = 0;
        while (pix_cnt < target && i < budget) begin
            tick(1);
            i++;
        end
        total++;
        if (pix_cnt < target) begin
            bad++;
            $display("FAIL wait_pix: got %0d want %0d", pix_cnt, target);
        end
    endtask

    task automatic rec_clear();
        obs_pix.delete();
        obs_addr.delete();
        rec_busy = 0;
    endtask

    task automatic one_frame(input logic [AW-1:0] b);
        int d0;
        d0 = done_cnt;
        base_addr = b;
        start = 1;
        tick(1);
        start = 0;
        wait_done(d0 + 1, 400);
        tick(1);
    endtask

    int exp_a[NP] = '{0, 0, 0, 0, 0,
                      0, 1, 2, 3, 0,
                      0, 4, 5, 6, 0,
                      0, 7, 8, 9, 0,
                      0, 0, 0, 0, 0};
    logic [AW-1:0] exp_b[9] = '{16'hFFFE, 16'hFFFF, 16'h0000,
                               16'h0001, 16'h0002, 16'h0003,
                               16'h0004, 16'h0005, 16'h0006};

    initial begin
        int d0, r0, n;
        for (int i = 0; i < 65536; i++) mem[i] = NW'($urandom);
        for (int i = 0; i < 9; i++) mem[16 + i] = NW'(i + 1);

        rst = 1;
        start = 1;
        tick(3);
        rst = 0;
        start = 0;
        tick(2);

        // Padded frame with known contents
        rec_clear();
        rec_en = 1;
        one_frame(16'h0010);
        rec_en = 0;
        chk("a_npix", 32'(obs_pix.size()), 32'(NP));
        n = (obs_pix.size() < NP) ? obs_pix.size() : NP;
        for (int i = 0; i < n; i++)
            chk("a_pix", 32'(obs_pix[i]), 32'(exp_a[i]));
        chk("a_nrd", 32'(obs_addr.size()), 32'd9);
        n = (obs_addr.size() < 9) ? obs_addr.size() : 9;
        for (int i = 0; i < n; i++)
            chk("a_addr", 32'(obs_addr[i]), 32'h10 + 32'(i));
        chk("a_busy_len", 32'(rec_busy), 32'd75);

        // Address wrap
        rec_clear();
        rec_en = 1;
        one_frame(16'hFFFE);
        rec_en = 0;
        chk("b_nrd", 32'(obs_addr.size()), 32'd9);
        n = (obs_addr.size() < 9) ? obs_addr.size() : 9;
        for (int i = 0; i < n; i++)
            chk("b_addr", 32'(obs_addr[i]), 32'(exp_b[i]));

        // Start held through done: back-to-back frames
        tick(2);
        d0 = done_cnt;
        r0 = rise_cnt;
        base_addr = 16'h0100;
        start = 1;
        wait_done(d0 + 2, 600);
        start = 0;
        tick(10);
        chk("bb_frames", 32'(rise_cnt - r0), 32'd2);
        if (rise_cyc.size() >= 1 && done_cyc.size() >= 2)
            chk("bb_gap", 32'(rise_cyc[rise_cyc.size() - 1]
                             - done_cyc[done_cyc.size() - 2]), 32'd2);

        // ce stall mid-frame
        d0 = done_cnt;
        r0 = pix_cnt;
        base_addr = 16'h0010;
        start = 1;
        tick(1);
        start = 0;
        wait_pix(r0 + 4, 200);
        ce = 0;
        tick(4);
        ce = 1;
        wait_done(d0 + 1, 400);
        chk("stall_npix", 32'(pix_cnt - r0), 32'(NP));

        // Reset mid-frame aborts without done
        tick(2);
        d0 = done_cnt;
        r0 = pix_cnt;
        base_addr = 16'h0010;
        start = 1;
        tick(1);
        start = 0;
        wait_pix(r0 + 5, 200);
        rst = 1;
        tick(1);
        rst = 0;
        tick(6);
        chk("abort_no_done", 32'(done_cnt), 32'(d0));
        rec_clear();
        rec_en = 1;
        r0 = pix_cnt;
        one_frame(16'h0010);
        rec_en = 0;
        chk("fresh_npix", 32'(pix_cnt - r0), 32'(NP));
        if (obs_addr.size() > 0)
            chk("fresh_addr0", 32'(obs_addr[0]), 32'h10);
        else
            chk("fresh_nrd", 32'(obs_addr.size()), 32'd9);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            ce = ($urandom_range(0, 7) != 0);
            start = ($urandom_range(0, 5) == 0);
            rst = ($urandom_range(0, 299) == 0);
            base_addr = AW'($urandom);
            tick(1);
        end
        rst = 0;
        start = 0;
        ce = 1;
        tick(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
